bcd_timer_ctrl: RTL and testbench

Run/stop/clear controller for a three-digit 8421-BCD count (000–999), plus the count itself and a programmable tick prescaler. Sequences the count enable from host commands and halts at a programmed BCD target in one-shot mode. Sits between the host control register and the decimal display/compare logic, replacing free-running BCD counting where start/stop/preset behaviour is needed.

---
 rtl/bcd_pkg.sv | 43 ++++
 rtl/bcd_digit_sclr.sv | 28 ++
 rtl/bcd_timer_ctrl.sv | 157 +++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD run/stop/clear timer: state encoding,
// BCD digit limits and small BCD helper functions.
package bcd_pkg;

    localparam int         BCD_W         = 12;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
        return (v[11:8] <= BCD_DIGIT_MAX) && (v[7:4] <= BCD_DIGIT_MAX)
            && (v[3:0] <= BCD_DIGIT_MAX);
    endfunction

    // Value the chained digit counters will hold after one step; used to
    // compare against the target before the step lands.
    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = v[11:8];
        t = v[7:4];
        u = v[3:0];
        if (u == BCD_DIGIT_MAX) begin
            u = 4'd0;
            if (t == BCD_DIGIT_MAX) begin
                t = 4'd0;
                h = (h == BCD_DIGIT_MAX) ? 4'd0 : h + 4'd1;
            end else begin
                t = t + 4'd1;
            end
        end else begin
            u = u + 4'd1;
        end
        return {h, t, u};
    endfunction

endpackage

// File: rtl/bcd_digit_sclr.sv
// One decade (0..9) counter with count enable, synchronous clear and
// carry-out asserted while the digit is 9 and being advanced.
module bcd_digit_sclr
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sclr,
    output logic [3:0] q,
    output logic       co
);

    assign co = en && (q == BCD_DIGIT_MAX);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (sclr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == BCD_DIGIT_MAX) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Run/stop/clear controller for a three-digit BCD count with prescaled
// stepping, free-run wrap and one-shot stop at a latched BCD target.
module bcd_timer_ctrl
    import bcd_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int DIV_W = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        mode,
    input  logic [11:0] target,
    output logic [11:0] cnt,
    output logic        running,
    output logic        done,
    output logic        wrap,
    output logic        err
);

    localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] presc, presc_nxt;
    logic [11:0]      target_q;
    logic             mode_q;
    logic             step, cnt_clr, latch;
    logic             err_nxt, done_nxt;
    logic             c_units, c_tens, c_hund;
    logic             go;
    logic             tgt_ok;

    // stop outranks start in every state; clear outranks both below.
    assign go     = start && !stop;
    assign tgt_ok = bcd_valid(target);

    // NOTE: every variable driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        step      = 1'b0;
        cnt_clr   = 1'b0;
        latch     = 1'b0;
        err_nxt   = err;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            presc_nxt = '0;
            cnt_clr   = 1'b1;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_clr = 1'b1;
                    if (go) begin
                        if (tgt_ok) begin
                            latch     = 1'b1;
                            presc_nxt = '0;
                            err_nxt   = 1'b0;
                            state_nxt = ST_RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Prescaler holds, so a dropped step fires on resume.
                        state_nxt = ST_PAUSE;
                    end else if (presc == PRESC_LAST) begin
                        step      = 1'b1;
                        presc_nxt = '0;
                        if (mode_q && (bcd_inc(cnt) == target_q)) begin
                            state_nxt = ST_DONE;
                            done_nxt  = 1'b1;
                        end
                    end else begin
                        presc_nxt = presc + DIV_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (go) state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (go) begin
                        if (tgt_ok) begin
                            latch     = 1'b1;
                            cnt_clr   = 1'b1;
                            presc_nxt = '0;
                            err_nxt   = 1'b0;
                            state_nxt = ST_RUN;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            presc    <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            wrap     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            running <= (state_nxt == ST_RUN);
            done    <= done_nxt;
            // Hundreds carry-out only fires on a 999 -> 000 step.
            wrap    <= c_hund && !mode_q;
            err     <= err_nxt;
            if (latch) begin
                target_q <= target;
                mode_q   <= mode;
            end
        end
    end

    bcd_digit_sclr u_units (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .sclr  (cnt_clr),
        .q     (cnt[3:0]),
        .co    (c_units)
    );

    bcd_digit_sclr u_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (c_units),
        .sclr  (cnt_clr),
        .q     (cnt[7:4]),
        .co    (c_tens)
    );

    bcd_digit_sclr u_hund (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (c_tens),
        .sclr  (cnt_clr),
        .q     (cnt[11:8]),
        .co    (c_hund)
    );

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Self-checking bench: two timers (DIV=1 and DIV=4) share stimulus and are
// compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, stop, clear, mode;
    logic [11:0] target;

    logic [11:0] cnt_a, cnt_b;
    logic        running_a, running_b, done_a, done_b;
    logic        wrap_a, wrap_b, err_a, err_b;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    bcd_timer_ctrl #(.DIV(1), .DIV_W(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .target(target), .cnt(cnt_a), .running(running_a),
        .done(done_a), .wrap(wrap_a), .err(err_a)
    );

    bcd_timer_ctrl #(.DIV(4), .DIV_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .target(target), .cnt(cnt_b), .running(running_b),
        .done(done_b), .wrap(wrap_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count kept as a plain integer 0..999.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int divs[2] = '{1, 4};
    int m_state[2], m_count[2], m_pre[2], m_tgt[2];
    bit m_mode[2], m_err[2], m_done[2], m_wrap[2];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got {cnt,run,done,wrap,err}=%h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic bit tgt_valid(input logic [11:0] t);
        return t[11:8] < 10 && t[7:4] < 10 && t[3:0] < 10;
    endfunction

    function automatic int tgt_dec(input logic [11:0] t);
        return int'(t[11:8]) * 100 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    task automatic model_reset(input int i);
        m_state[i] = M_IDLE; m_count[i] = 0; m_pre[i] = 0; m_tgt[i] = 0;
        m_mode[i]  = 1'b0;   m_err[i]   = 1'b0; m_done[i] = 1'b0; m_wrap[i] = 1'b0;
    endtask

    task automatic model_start(input int i);
        if (!tgt_valid(target)) begin
            m_err[i] = 1'b1;
        end else begin
            m_err[i] = 1'b0; m_tgt[i] = tgt_dec(target); m_mode[i] = mode;
            m_pre[i] = 0;    m_count[i] = 0;             m_state[i] = M_RUN;
        end
    endtask

    task automatic model_step(input int i);
        m_done[i] = 1'b0;
        m_wrap[i] = 1'b0;
        if (clear) begin
            m_state[i] = M_IDLE; m_count[i] = 0; m_pre[i] = 0; m_err[i] = 1'b0;
        end else begin
            case (m_state[i])
                M_IDLE:  if (start && !stop) model_start(i);
                M_DONE:  if (start && !stop) model_start(i);
                M_PAUSE: if (start && !stop) m_state[i] = M_RUN;
                default: begin
                    if (stop) begin
                        m_state[i] = M_PAUSE;
                    end else if (m_pre[i] == divs[i] - 1) begin
                        m_pre[i]   = 0;
                        m_count[i] = (m_count[i] + 1) % 1000;
                        if (!m_mode[i] && m_count[i] == 0) m_wrap[i] = 1'b1;
                        if (m_mode[i] && m_count[i] == m_tgt[i]) begin
                            m_state[i] = M_DONE;
                            m_done[i]  = 1'b1;
                        end
                    end else begin
                        m_pre[i]++;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        logic [15:0] obs;
        logic [15:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            obs = (i == 0) ? {cnt_a, running_a, done_a, wrap_a, err_a}
                           : {cnt_b, running_b, done_b, wrap_b, err_b};
            exp_v = {to_bcd(m_count[i]), m_state[i] == M_RUN, m_done[i], m_wrap[i], m_err[i]};
            check($sformatf("div%0d_cyc%0d", divs[i], cyc), obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else        model_step(i);
        end
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle_cmds();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_start(input logic md, input logic [11:0] tg);
        mode = md; target = tg; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    // Asserts reset between edges and checks outputs before the next edge.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        #1;
        check_all();
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; target = 12'h000;
        idle_cmds();
        for (int i = 0; i < 2; i++) model_reset(i);
        ticks(3);
        rst_n = 1'b1;
        ticks(3);

        // Reset in the middle of a run.
        pulse_start(1'b0, 12'h000);
        ticks(9);
        async_reset();

        // One-shot to 025.
        pulse_start(1'b1, 12'h025);
        mode = 1'b0; target = 12'h777;
        ticks(40);
        pulse_clear();

        // Free-run across 999 -> 000.
        pulse_start(1'b0, 12'h000);
        ticks(1010);
        pulse_clear();

        // Stop/resume mid-prescale, and stop coincident with a step.
        pulse_start(1'b0, 12'h000);
        ticks(2);
        pulse_stop();
        ticks(10);
        pulse_start(1'b0, 12'h000);
        ticks(5);
        pulse_stop();
        ticks(4);
        pulse_start(1'b0, 12'h000);
        ticks(6);
        pulse_clear();

        // Invalid target sets err, valid start clears it.
        pulse_start(1'b1, 12'h0A3);
        ticks(3);
        pulse_start(1'b1, 12'h003);
        ticks(16);

        // Restart from DONE with a new target, then clear with all commands.
        pulse_start(1'b1, 12'h007);
        ticks(3);
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        tick();
        idle_cmds();
        ticks(3);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            clear = ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 4);
            start = ($urandom_range(0, 99) < 10);
            mode  = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) target = 12'($urandom);
            else                           target = to_bcd($urandom_range(0, 60));
            if ($urandom_range(0, 499) == 0) begin
                idle_cmds();
                async_reset();
            end else begin
                tick();
            end
        end
        idle_cmds();
        ticks(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
